// File: rtl/drive_steer_ctrl.sv
// Purpose : bidirectional line-following steering FSM; picks front/back IR+IP
//           sensors by travel direction, holds turns, coasts then declares
//           line-lost, and brakes on obstacles and direction reversals.
// Latency : one registered stage; inputs sampled at edge k show on outputs
//           after edge k, with no combinational input-to-output path.
// Backpressure: none; every input is re-evaluated each cycle.
// Ports   : clock, reset (async, active-high); canMove, isMoving_forward;
//           sensorIR_front/back (active-low obstacle);
//           sensIP_front/back[N_SENS] (bit 0 = right-most);
//           sendToH_BridgeINs[4] (registered H-bridge code);
//           driveState[3]; lineLost.
module drive_steer_ctrl #(
  parameter int N_SENS     = 4,
  parameter int HOLD_TICKS = 25000000,
  parameter int LOST_TICKS = 50000000,
  parameter int STOP_TICKS = 25000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              canMove,
  input  logic              isMoving_forward,
  input  logic              sensorIR_front,
  input  logic              sensorIR_back,
  input  logic [N_SENS-1:0] sensIP_front,
  input  logic [N_SENS-1:0] sensIP_back,
  output logic [3:0]        sendToH_BridgeINs,
  output logic [2:0]        driveState,
  output logic              lineLost
);

  localparam int HALF  = N_SENS / 2;
  localparam int MAXHL = (HOLD_TICKS > LOST_TICKS) ? HOLD_TICKS : LOST_TICKS;
  localparam int MAXT  = (MAXHL > STOP_TICKS) ? MAXHL : STOP_TICKS;
  // Guard against a zero-width counter when every tick parameter is 1.
  localparam int CW    = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [3:0] INERTIAL_STOP = 4'b0000;
  localparam logic [3:0] HARD_STOP     = 4'b1111;
  localparam logic [3:0] FORWARD       = 4'b0110;
  localparam logic [3:0] REVERSE       = 4'b1001;
  localparam logic [3:0] TURN_RIGHT    = 4'b0101;
  localparam logic [3:0] TURN_LEFT     = 4'b1010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    TURN  = 3'd2,
    COAST = 3'd3,
    BRAKE = 3'd4,
    LOST  = 3'd5
  } stateT;

  stateT          state, stateNext;
  logic [3:0]     outReg, outNext;
  logic [CW-1:0]  cnt, cntNext;
  logic           prevDir;

  logic              activeIr;
  logic [N_SENS-1:0] activeIp;
  int                hiCount, loCount;
  logic              ipLost, ipStraight;
  logic [3:0]        turnCode, straightCode;
  logic              toggle;

  stateT          ruleState;
  logic [3:0]     ruleOut;
  logic [CW-1:0]  ruleCnt;

  // Sensor selection and decode of the active IP vector.
  always_comb begin
    activeIr = isMoving_forward ? sensorIR_front : sensorIR_back;
    activeIp = isMoving_forward ? sensIP_front : sensIP_back;
    hiCount  = 0;
    loCount  = 0;
    for (int i = 0; i < HALF; i++) begin
      loCount = loCount + int'(activeIp[i]);
      hiCount = hiCount + int'(activeIp[i+HALF]);
    end
    ipLost       = (activeIp == '0);
    ipStraight   = (hiCount == loCount);
    straightCode = isMoving_forward ? FORWARD : REVERSE;
    // Left/right swap in reverse because the back sensors face the other way.
    if (loCount > hiCount) turnCode = isMoving_forward ? TURN_RIGHT : TURN_LEFT;
    else                   turnCode = isMoving_forward ? TURN_LEFT : TURN_RIGHT;
    toggle = (isMoving_forward != prevDir);
  end

  // Common "drive rules" outcome, reused by IDLE/DRIVE/TURN/COAST/BRAKE.
  always_comb begin
    ruleState = DRIVE;
    ruleOut   = straightCode;
    ruleCnt   = '0;
    if (ipLost) begin
      ruleState = COAST;
      ruleOut   = INERTIAL_STOP;
      ruleCnt   = CW'(LOST_TICKS - 1);
    end else if (!ipStraight) begin
      ruleState = TURN;
      ruleOut   = turnCode;
      ruleCnt   = CW'(HOLD_TICKS - 1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext = state;
    outNext   = outReg;
    cntNext   = cnt;
    if (!canMove) begin
      stateNext = IDLE;
      outNext   = INERTIAL_STOP;
      cntNext   = '0;
    end else if ((state != IDLE) && !activeIr) begin
      // Reloaded every IR-low cycle so the stop time runs from the last one.
      stateNext = BRAKE;
      outNext   = HARD_STOP;
      cntNext   = CW'(STOP_TICKS - 1);
    end else if (toggle && ((state == DRIVE) || (state == TURN) || (state == COAST))) begin
      stateNext = BRAKE;
      outNext   = HARD_STOP;
      cntNext   = CW'(STOP_TICKS - 1);
    end else begin
      case (state)
        IDLE, DRIVE: begin
          stateNext = ruleState;
          outNext   = ruleOut;
          cntNext   = ruleCnt;
        end
        TURN: begin
          // Latched turn code stays in outReg; IP is ignored until expiry.
          if (cnt == '0) begin
            stateNext = ruleState;
            outNext   = ruleOut;
            cntNext   = ruleCnt;
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        COAST: begin
          outNext = INERTIAL_STOP;
          if (!ipLost) begin
            stateNext = ruleState;
            outNext   = ruleOut;
            cntNext   = ruleCnt;
          end else if (cnt == '0) begin
            stateNext = LOST;
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        LOST: begin
          outNext = INERTIAL_STOP;
        end
        BRAKE: begin
          outNext = HARD_STOP;
          if (cnt == '0) begin
            stateNext = ruleState;
            outNext   = ruleOut;
            cntNext   = ruleCnt;
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        default: begin
          stateNext = IDLE;
          outNext   = INERTIAL_STOP;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      outReg  <= INERTIAL_STOP;
      cnt     <= '0;
      prevDir <= 1'b1;
    end else begin
      state   <= stateNext;
      outReg  <= outNext;
      cnt     <= cntNext;
      prevDir <= isMoving_forward;
    end
  end

  assign sendToH_BridgeINs = outReg;
  assign driveState        = state;
  assign lineLost          = (state == LOST);

endmodule

// File: doc/drive_steer_ctrl.md
# drive_steer_ctrl

Bidirectional, parametrised line-following steering controller for the rover. It replaces the single-direction reverse-only steering path by serving both travel directions from one FSM. It selects front or back IR/IP sensors by direction, holds turns for a minimum time, coasts and then declares line-lost on sensor dropout, and brakes on obstacles and direction reversals. Its registered 4-bit output drives the H-bridge IN1..IN4 routing.

## Interface
- N_SENS, 4 — IP line sensors per side; even, ≥2.
- HOLD_TICKS, 25000000 — minimum cycles a turn code is held (0.5 s at 50 MHz); ≥1.
- LOST_TICKS, 50000000 — coast cycles allowed before line-lost; ≥1.
- STOP_TICKS, 25000000 — hard-stop cycles after obstacle clears or direction reversal; ≥1.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- canMove  in  1  1 = motion enabled by the audio command; 0 = stop.
- isMoving_forward  in  1  1 = forward, 0 = reverse.
- sensorIR_front  in  1  active-low obstacle, front.
- sensorIR_back  in  1  active-low obstacle, back.
- sensIP_front  in  N_SENS  front line sensors; bit 0 = right-most.
- sensIP_back  in  N_SENS  back line sensors; bit 0 = right-most.
- sendToH_BridgeINs  out  4  H-bridge code, registered.
- driveState  out  3  IDLE=0, DRIVE=1, TURN=2, COAST=3, BRAKE=4, LOST=5.
- lineLost  out  1  1 while in LOST.

## Operation
- Codes: INERTIAL_STOP=0000, HARD_STOP=1111, FORWARD=0110, REVERSE=1001, TURN_RIGHT=0101, TURN_LEFT=1010.
- Active set: forward uses sensorIR_front/sensIP_front; reverse uses back.
- Decode of active IP vector s:
  - H = popcount(s[N_SENS-1:N_SENS/2]); L = popcount(s[N_SENS/2-1:0]).
  - s==0 → lost.
  - H==L → straight: FORWARD or REVERSE per direction.
  - L>H → TURN_RIGHT if forward, TURN_LEFT if reverse.
  - H>L → TURN_LEFT if forward, TURN_RIGHT if reverse.
- Priority, evaluated every cycle: reset > canMove=0 > active IR low > direction toggle > state rules.
- canMove=0, any state: go to IDLE, output 0000, lineLost=0, counter cleared.
- Active IR low, any non-IDLE state: go to BRAKE, output 1111, counter reloads STOP_TICKS-1 every such cycle.
- Direction toggle: isMoving_forward differs from its registered previous value while in DRIVE/TURN/COAST. Go to BRAKE and load STOP_TICKS-1. In LOST, a toggle is ignored.
- IDLE: output 0000. If canMove=1, apply DRIVE rules this cycle.
- DRIVE:
  - straight → stay in DRIVE with the straight code.
  - turn → go to TURN with the turn code; load HOLD_TICKS-1.
  - lost → go to COAST with 0000; load LOST_TICKS-1.
- TURN: hold the latched turn code and ignore IP. Decrement the counter; at counter 0, apply DRIVE rules.
- COAST:
  - Output 0000.
  - Non-lost decode → apply DRIVE rules.
  - Else decrement; at counter 0 with still lost → go to LOST.
- LOST: output 0000, lineLost=1. Exit only via canMove=0 or IR.
- BRAKE:
  - Output 1111.
  - IR high: decrement. At counter 0 with IR high, apply DRIVE rules for the current direction.
- Counter: single down-counter, width $clog2(max(HOLD_TICKS, LOST_TICKS, STOP_TICKS)). It never wraps below 0.

## Timing
- Reset values:
  - sendToH_BridgeINs=0000
  - driveState=IDLE
  - lineLost=0
  - counter=0
  - previous-direction register = 1
- Latency: input sampled at edge k appears on the outputs after edge k (one registered stage); no combinational input-to-output path.
- A turn code is on the output for exactly HOLD_TICKS cycles before re-decode. HOLD_TICKS=1 re-decodes the following cycle.
- COAST lasts exactly LOST_TICKS cycles before LOST if the line stays lost.
- BRAKE outputs 1111 for exactly STOP_TICKS cycles after the last IR-low cycle or toggle cycle.
- Reset mid-TURN/BRAKE: asynchronous return to reset values; the hold is not resumed.
- Simultaneous IR low and toggle: BRAKE, single load of STOP_TICKS-1.

## Test plan
Parameters: N_SENS=4, HOLD_TICKS=4, LOST_TICKS=6, STOP_TICKS=3.
- Reset and start: reset, then canMove=1, forward, sensIP_front=0110 → 0110 and DRIVE one cycle after canMove.
- Turn hold: forward, sensIP_front=0001 for 1 cycle, then 0110 → 0101 for exactly 4 cycles, then 0110. Repeat in reverse with sensIP_back=0001 → 1010 for 4 cycles.
- Line lost:
  - forward, sensIP_front=0000 → 0000 in COAST for 6 cycles, then LOST with lineLost=1.
  - Then sensIP_front=0110 → stays LOST.
  - Then canMove=0 → IDLE, lineLost=0.
- Obstacle: DRIVE forward, sensorIR_front=0 for 2 cycles → 1111 during those cycles plus 3 more, then 0110. sensorIR_back=0 in forward → no effect.
- Reversal: in DRIVE forward, toggle isMoving_forward=0 with sensIP_back=0110 → 1111 for 3 cycles, then 1001.
- Async reset mid-TURN: assert reset between edges → output 0000 and driveState 0 immediately.
